demux32bits2salidas: RTL

1-to-2 demultiplexer for 32-bit words with a valid/ready handshake and a 2-entry buffer on each output. It performs the inverse of the datapath's 2-input 32-bit selector: one producer word is steered to output A or output B by `sel`. It sits where a single result stream must be distributed to one of two consumers, for example a write-back value routed to the register file or to the memory stage. Each consumer may stall independently.

---
 rtl/demux32bits2salidas.sv | 116 +++++++++++
 1 files changed

// File: rtl/demux32bits2salidas.sv
// 1-to-2 word demultiplexer: sel steers each accepted word into one of two 2-entry FIFOs.
// Optional per-output acceptance counters are built when DEMUX_CONTADORES_EN is defined.

module demux32bits2salidas_fifo #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [ANCHO-1:0] din_i,
  input  logic             pop_i,
  output logic [ANCHO-1:0] dout_o,
  output logic             valid_o,
  output logic             free_o
);
  logic [1:0][ANCHO-1:0] mem_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  wr_q, rd_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign free_o  = (cnt_q != 2'd2);
  // Head word is forced to zero while empty so stale storage never shows.
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
endmodule

module demux32bits2salidas #(
  parameter int ANCHO        = 32,
  parameter int CUENTA_ANCHO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [ANCHO-1:0] entrada,
  input  logic             entrada_valid,
  output logic             entrada_ready,
  output logic [ANCHO-1:0] salidaA,
  output logic             validA,
  input  logic             readyA,
  output logic [ANCHO-1:0] salidaB,
  output logic             validB,
  input  logic             readyB
`ifdef DEMUX_CONTADORES_EN
  ,
  output logic [CUENTA_ANCHO-1:0] cuentaA,
  output logic [CUENTA_ANCHO-1:0] cuentaB
`endif
);
  logic [1:0]            push, pop, vld, free, rdy;
  logic [1:0][ANCHO-1:0] dout;

  assign rdy = {readyB, readyA};
  // Ready looks only at the selected FIFO's occupancy, never at the consumer.
  assign entrada_ready = free[sel];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign push[g] = entrada_valid & entrada_ready & (sel == 1'(g));
    assign pop[g]  = vld[g] & rdy[g];

    demux32bits2salidas_fifo #(.ANCHO(ANCHO)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push[g]),
      .din_i  (entrada),
      .pop_i  (pop[g]),
      .dout_o (dout[g]),
      .valid_o(vld[g]),
      .free_o (free[g])
    );
  end

  assign salidaA = dout[0];
  assign salidaB = dout[1];
  assign validA  = vld[0];
  assign validB  = vld[1];

`ifdef DEMUX_CONTADORES_EN
  logic [1:0][CUENTA_ANCHO-1:0] cuenta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (push[i]) cuenta_q[i] <= cuenta_q[i] + 1'b1;
    end
  end

  assign cuentaA = cuenta_q[0];
  assign cuentaB = cuenta_q[1];
`endif
endmodule
